// File: rtl/sc_stream_to_binary_if.sv
// sc_stream_to_binary_if: request/result bundle for the stochastic-to-binary converter
//   start, len, bit_in : conversion request and the stochastic bitstream (producer side)
//   busy               : converter occupied (RUN or DONE)
//   result, result_valid, result_ready : count handshake toward the consumer
interface sc_stream_to_binary_if #(parameter int CW = 16);
    logic          start;
    logic [CW-1:0] len;
    logic          bit_in;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    modport master (
        output start, len, bit_in, result_ready,
        input  busy, result, result_valid
    );
    modport slave (
        input  start, len, bit_in, result_ready,
        output busy, result, result_valid
    );
endinterface

// File: rtl/sc_stream_to_binary.sv
// sc_stream_to_binary: counts 1s of a stochastic bitstream over a programmable window
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   s   : slave side of sc_stream_to_binary_if (start/len/bit_in in, busy/result/result_valid out, result_ready in)
module sc_stream_to_binary #(parameter int CW = 16) (
    input logic                 clk,
    input logic                 rst,
    sc_stream_to_binary_if.slave s
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] acc, rem, result_q;
    logic [CW-1:0] acc_nx;
    logic          take;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    always_comb begin
        take     = state == IDLE && s.start;
        acc_nx   = acc + CW'(s.bit_in);
        state_nx = state;
        if (state == IDLE)
            state_nx = s.start ? (s.len == '0 ? DONE : RUN) : IDLE;
        else if (state == RUN)
            state_nx = rem == CW'(1) ? DONE : RUN;
        else
            state_nx = s.result_ready ? IDLE : DONE;
    end
    // The last bit of the window is folded into the result on the same edge it is sampled.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            acc      <= '0;
            rem      <= '0;
            result_q <= '0;
        end else if (take) begin
            acc <= '0;
            rem <= s.len;
            if (s.len == '0) result_q <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            rem <= rem - CW'(1);
            if (rem == CW'(1)) result_q <= acc_nx;
        end
    always_comb begin
        s.busy         = state != IDLE;
        s.result_valid = state == DONE;
        s.result       = result_q;
    end
endmodule

// File: tb/tb_sc_stream_to_binary.sv
// tb_sc_stream_to_binary: table vectors, corner sequences and random windows against a counting model
module tb_sc_stream_to_binary;
    logic clk = 0;
    logic rst = 0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rises[$];
    bit   bq[$];
    sc_stream_to_binary_if #(16) s ();
    sc_stream_to_binary_if #(4)  t ();
    sc_stream_to_binary #(.CW(16)) dut  (.clk(clk), .rst(rst), .s(s.slave));
    sc_stream_to_binary #(.CW(4))  dut4 (.clk(clk), .rst(rst), .s(t.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge s.busy) rises.push_back(cyc);
    typedef struct {
        int          len;
        logic [31:0] pat;
        int          hold;
        int          exp;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    function automatic int ones();
        int n = 0;
        foreach (bq[i]) n += int'(bq[i]);
        return n;
    endfunction
    task automatic fill_pat(input int n, input logic [31:0] pat);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(pat[i]);
    endtask
    task automatic fill_rand(input int n, input int pct);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back($urandom_range(0, 99) < pct);
    endtask
    task automatic run_window(input int L, input int exp, input int hold, input string nm);
        int bad;
        bad = 0;
        s.start = 1;
        s.len = 16'(L);
        @(posedge clk); #1;
        s.start = 0;
        s.len = 16'($urandom);
        for (int k = 0; k < L; k++) begin
            if (s.busy !== 1'b1 || s.result_valid !== 1'b0) bad++;
            s.bit_in = bq[k];
            @(posedge clk); #1;
        end
        s.bit_in = 1'($urandom);
        chk({nm, " early"}, bad, 0);
        chk({nm, " valid"}, s.result_valid, 1);
        chk({nm, " result"}, s.result, exp);
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (s.result_valid !== 1'b1 || s.result !== 16'(exp)) bad++;
        end
        if (hold > 0) chk({nm, " hold"}, bad, 0);
        s.result_ready = 1;
        @(posedge clk); #1;
        s.result_ready = 0;
        chk({nm, " idle busy"}, s.busy, 0);
        chk({nm, " idle valid"}, s.result_valid, 0);
        chk({nm, " kept result"}, s.result, exp);
    endtask
    initial begin
        int bad, exp, L, d;
        s.start = 0; s.len = 0; s.bit_in = 0; s.result_ready = 0;
        t.start = 0; t.len = 0; t.bit_in = 0; t.result_ready = 0;
        #1;
        chk("reset busy", s.busy, 0);
        chk("reset valid", s.result_valid, 0);
        chk("reset result", s.result, 0);
        chk("reset cw4 valid", t.result_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("idle busy", s.busy, 0);
        tbl[0] = '{8,  32'h0000_004D, 0, 4};
        tbl[1] = '{0,  32'hFFFF_FFFF, 0, 0};
        tbl[2] = '{1,  32'h0000_0001, 0, 1};
        tbl[3] = '{1,  32'h0000_0000, 2, 0};
        tbl[4] = '{16, 32'h0000_FFFF, 0, 16};
        tbl[5] = '{12, 32'hFFFF_F0A5, 3, 4};
        tbl[6] = '{5,  32'hFFFF_FFE0, 0, 0};
        tbl[7] = '{32, 32'h8000_0001, 1, 2};
        foreach (tbl[i]) begin
            fill_pat(tbl[i].len, tbl[i].pat);
            run_window(tbl[i].len, tbl[i].exp, tbl[i].hold, $sformatf("vec%0d", i));
        end
        // starts during RUN and DONE, and on the handshake cycle, must be ignored
        fill_pat(10, 32'h0000_02D3);
        s.start = 1; s.len = 10;
        @(posedge clk); #1;
        s.start = 0;
        for (int k = 0; k < 10; k++) begin
            s.start = k == 3;
            s.len = 3;
            s.bit_in = bq[k];
            @(posedge clk); #1;
        end
        chk("ign valid", s.result_valid, 1);
        chk("ign result", s.result, 6);
        bad = 0;
        s.start = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            s.start = 0;
            if (s.result_valid !== 1'b1 || s.result !== 16'd6) bad++;
        end
        chk("ign hold", bad, 0);
        s.result_ready = 1; s.start = 1;
        @(posedge clk); #1;
        s.result_ready = 0; s.start = 0;
        chk("ign hs busy", s.busy, 0);
        @(posedge clk); #1;
        chk("ign after busy", s.busy, 0);
        chk("ign after valid", s.result_valid, 0);
        // asynchronous reset in cycle 5 of a 20-cycle window
        s.start = 1; s.len = 20;
        @(posedge clk); #1;
        s.start = 0;
        for (int k = 0; k < 4; k++) begin
            s.bit_in = 1;
            @(posedge clk); #1;
        end
        chk("pre rst busy", s.busy, 1);
        #2 rst = 0;
        #1;
        chk("async busy", s.busy, 0);
        chk("async valid", s.result_valid, 0);
        chk("async result", s.result, 0);
        @(posedge clk); #1;
        rst = 1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (s.busy !== 1'b0 || s.result_valid !== 1'b0) bad++;
        end
        chk("aborted stays idle", bad, 0);
        fill_pat(4, 32'hF);
        run_window(4, 4, 0, "post rst");
        // 4-bit counter: full-length window must not wrap
        for (int r = 0; r < 2; r++) begin
            t.start = 1; t.len = 4'd15;
            @(posedge clk); #1;
            t.start = 0;
            for (int k = 0; k < 15; k++) begin
                t.bit_in = r == 0;
                @(posedge clk); #1;
            end
            chk($sformatf("cw4 valid%0d", r), t.result_valid, 1);
            chk($sformatf("cw4 result%0d", r), t.result, r == 0 ? 15 : 0);
            t.result_ready = 1;
            @(posedge clk); #1;
            t.result_ready = 0;
        end
        // random short windows
        for (int r = 0; r < 10; r++) begin
            L = $urandom_range(1, 300);
            fill_rand(L, $urandom_range(0, 100));
            run_window(L, ones(), $urandom_range(0, 3), $sformatf("rnd%0d", r));
        end
        // back-to-back long windows, P(1)=0.25
        rises.delete();
        for (int r = 0; r < 2; r++) begin
            fill_rand(4096, 25);
            exp = ones();
            chk($sformatf("long%0d range", r), exp >= 928 && exp <= 1120, 1);
            run_window(4096, exp, 0, $sformatf("long%0d", r));
        end
        chk("long starts seen", rises.size(), 2);
        d = rises.size() >= 2 ? rises[1] - rises[0] : -1;
        chk("long period", d, 4098);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
